counter_enable_seq: RTL and testbench

Enable sequencer that sits directly upstream of the 4-bit `counter` and drives its `reset` and `enable` inputs. On a start request it clears the counter, then issues a programmable number of enable bursts, each a fixed run length followed by a fixed gap. It reports progress and completion to the controlling logic. An optional checker watches the counter's `count` output and flags any mismatch against the expected value.

---
 rtl/counter_seq_pkg.sv | 22 ++
 rtl/seq_timer.sv | 30 +++
 rtl/counter_enable_seq.sv | 197 +++++++++++++++++++
 tb/tb_counter_enable_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter enable sequencer.
package counter_seq_pkg;

  localparam int DEF_RUN_W   = 8;
  localparam int DEF_GAP_W   = 8;
  localparam int DEF_BURST_W = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  // Width of a timer that must hold either a run length or a gap length.
  function automatic int maxWidth(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the RUN and GAP phases of the sequencer.
// Counts down to zero and holds there until the next load.
module seq_timer
  import counter_seq_pkg::*;
#(
  parameter int W = DEF_RUN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise step down and park at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/counter_enable_seq.sv
// Enable sequencer driving the reset/enable inputs of a 4-bit counter.
// A start clears the counter, then issues bursts of run_len enable cycles
// separated by gap_len idle cycles, burst_num times (0 = until stop).
// Optional feature macro: COUNTER_SEQ_CHECK_EN adds a checker that tracks
// the expected counter value and raises a sticky mismatch flag.
module counter_enable_seq
  import counter_seq_pkg::*;
#(
  parameter int RUN_W   = DEF_RUN_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [RUN_W-1:0]   run_len,
  input  logic [GAP_W-1:0]   gap_len,
  input  logic [BURST_W-1:0] burst_num,
  input  logic [CNT_W-1:0]   count,
  output logic               counter_reset,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] bursts_done,
  output logic               mismatch
);

  localparam int TW = maxWidth(RUN_W, GAP_W);

  seq_state_t         r_state;
  seq_state_t         w_nextState;
  logic [RUN_W-1:0]   r_runLen;
  logic [GAP_W-1:0]   r_gapLen;
  logic [BURST_W-1:0] r_burstNum;
  logic [BURST_W-1:0] r_burstsDone;
  logic               r_counterReset;
  logic               r_enable;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_runEnd;
  logic               w_timerLoad;
  logic [TW-1:0]      w_timerValue;
  logic               w_timerZero;
  logic [TW-1:0]      w_runReload;
  logic [TW-1:0]      w_gapReload;
  logic [BURST_W-1:0] w_burstInc;
  logic               w_finalBurst;

  // Timer reload values use the configuration latched at start, so the
  // inputs may change freely while a sequence is running.
  assign w_runReload = TW'(r_runLen) - TW'(1);
  assign w_gapReload = TW'(r_gapLen) - TW'(1);

  // Completed-burst count saturates so an endless sequence cannot wrap it.
  assign w_burstInc   = (r_burstsDone == {BURST_W{1'b1}}) ? r_burstsDone
                                                          : r_burstsDone + BURST_W'(1);
  assign w_finalBurst = (r_burstNum != '0) && (w_burstInc == r_burstNum);

  seq_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (w_timerLoad),
    .value  (w_timerValue),
    .zero   (w_timerZero)
  );

  // Next-state and timer-load decisions; stop overrides everything outside IDLE.
  always_comb begin
    w_nextState  = r_state;
    w_accept     = 1'b0;
    w_runEnd     = 1'b0;
    w_timerLoad  = 1'b0;
    w_timerValue = w_runReload;
    case (r_state)
      IDLE: begin
        if (start && !stop && (run_len != '0)) begin
          w_nextState = CLR;
          w_accept    = 1'b1;
        end
      end
      CLR: begin
        if (stop) begin
          w_nextState = DONE;
        end else begin
          w_nextState = RUN;
          w_timerLoad = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          w_nextState = DONE;
        end else if (w_timerZero) begin
          w_runEnd = 1'b1;
          if (w_finalBurst) begin
            w_nextState = DONE;
          end else if (r_gapLen != '0) begin
            w_nextState  = GAP;
            w_timerLoad  = 1'b1;
            w_timerValue = w_gapReload;
          end else begin
            w_timerLoad = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          w_nextState = DONE;
        end else if (w_timerZero) begin
          w_nextState = RUN;
          w_timerLoad = 1'b1;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register with outputs registered as decodes of the next state,
  // plus configuration latching and the completed-burst counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_counterReset <= 1'b0;
      r_enable       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_runLen       <= '0;
      r_gapLen       <= '0;
      r_burstNum     <= '0;
      r_burstsDone   <= '0;
    end else begin
      r_state        <= w_nextState;
      r_counterReset <= (w_nextState == CLR);
      r_enable       <= (w_nextState == RUN);
      r_busy         <= (w_nextState == CLR) || (w_nextState == RUN) ||
                        (w_nextState == GAP);
      r_done         <= (w_nextState == DONE);
      if (w_accept) begin
        r_runLen     <= run_len;
        r_gapLen     <= gap_len;
        r_burstNum   <= burst_num;
        r_burstsDone <= '0;
      end else if (w_runEnd) begin
        r_burstsDone <= w_burstInc;
      end
    end
  end

  assign counter_reset = r_counterReset;
  assign enable        = r_enable;
  assign busy          = r_busy;
  assign done          = r_done;
  assign bursts_done   = r_burstsDone;

`ifdef COUNTER_SEQ_CHECK_EN
  logic [CNT_W-1:0] r_expect;
  logic             r_mismatch;

  // Shadow of the counter: cleared with it, stepped on every enabled edge;
  // any disagreement while the counter is meaningful latches mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_expect   <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (r_state == CLR) begin
        r_expect <= '0;
      end else if (r_enable) begin
        r_expect <= r_expect + CNT_W'(1);
      end
      if (w_accept) begin
        r_mismatch <= 1'b0;
      end else if (((r_state == RUN) || (r_state == GAP) || (r_state == DONE)) &&
                   (count != r_expect)) begin
        r_mismatch <= 1'b1;
      end
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unusedCount;

  assign w_unusedCount = ^count;
  assign mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_counter_enable_seq.sv
// Self-checking bench for counter_enable_seq with a behavioural 4-bit counter.
// Build with COUNTER_SEQ_CHECK_EN to also exercise the mismatch checker.
module tb_counter_enable_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [7:0] run_len;
  logic [7:0] gap_len;
  logic [3:0] burst_num;
  logic [3:0] countIn;
  logic       counter_reset;
  logic       enable;
  logic       busy;
  logic       done;
  logic [3:0] bursts_done;
  logic       mismatch;

  logic [3:0] tbCount = 4'd0;
  logic       fault;

`ifdef COUNTER_SEQ_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  typedef struct {
    int runLen;
    int gapLen;
    int burstNum;
    int stopCycle;
    int injectCycle;
  } vec_t;

  typedef struct {
    bit cr;
    bit en;
    bit busy;
    bit done;
    bit burstEnd;
    bit chkMis;
    bit chkRes;
    bit expMis;
    int expBursts;
    int expCount;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;

  counter_enable_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .run_len      (run_len),
    .gap_len      (gap_len),
    .burst_num    (burst_num),
    .count        (countIn),
    .counter_reset(counter_reset),
    .enable       (enable),
    .busy         (busy),
    .done         (done),
    .bursts_done  (bursts_done),
    .mismatch     (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural model of the downstream counter.
  always @(posedge clk) begin
    if (counter_reset) tbCount <= 4'd0;
    else if (enable)   tbCount <= tbCount + 4'd1;
  end

  assign countIn = tbCount + {3'b000, fault};

  initial begin
    #500000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit cr, input bit en, input bit bz, input bit dn);
    exp_t e;
    e = '{default: 0};
    e.cr   = cr;
    e.en   = en;
    e.busy = bz;
    e.done = dn;
    return e;
  endfunction

  task automatic checkAllZero(input string tag);
    checkVal({tag, " counter_reset"}, int'(counter_reset), 0);
    checkVal({tag, " enable"},        int'(enable),        0);
    checkVal({tag, " busy"},          int'(busy),          0);
    checkVal({tag, " done"},          int'(done),          0);
    checkVal({tag, " bursts_done"},   int'(bursts_done),   0);
    checkVal({tag, " mismatch"},      int'(mismatch),      0);
  endtask

  task automatic checkOutput(input int vi, input int c);
    exp_t  e;
    string tag;
    e   = sbQ.pop_front();
    tag = $sformatf("v%0d c%0d", vi, c);
    checkVal({tag, " counter_reset"}, int'(counter_reset), int'(e.cr));
    checkVal({tag, " enable"},        int'(enable),        int'(e.en));
    checkVal({tag, " busy"},          int'(busy),          int'(e.busy));
    checkVal({tag, " done"},          int'(done),          int'(e.done));
    if (e.chkRes) begin
      checkVal({tag, " bursts_done"}, int'(bursts_done), e.expBursts);
      checkVal({tag, " count"},       int'(tbCount),     e.expCount);
      checkVal({tag, " mismatch"},    int'(mismatch),    int'(e.expMis));
    end else if (e.chkMis) begin
      checkVal({tag, " mismatch"},    int'(mismatch),    int'(e.expMis));
    end
  endtask

  // Builds the expected cycle-by-cycle schedule for one vector, then drives it.
  task automatic applyStimulus(input vec_t v, input int vi);
    exp_t gen[$];
    exp_t e;
    int   bursts;
    int   doneB;
    int   enCnt;
    bursts = (v.burstNum == 0) ? 64 : v.burstNum;
    gen.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
    for (int b = 0; b < bursts; b++) begin
      for (int r = 0; r < v.runLen; r++) begin
        e = mk(1'b0, 1'b1, 1'b1, 1'b0);
        e.burstEnd = (r == v.runLen - 1);
        gen.push_back(e);
      end
      if (b != bursts - 1) begin
        for (int g = 0; g < v.gapLen; g++) gen.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      end
    end
    if (v.stopCycle != 0) begin
      while (gen.size() > v.stopCycle) void'(gen.pop_back());
    end
    doneB = 0;
    enCnt = 0;
    foreach (gen[i]) begin
      if (gen[i].en) enCnt++;
      if (gen[i].burstEnd && ((v.stopCycle == 0) || (i + 1 < v.stopCycle))) doneB++;
    end
    gen[0].chkMis = 1'b1;
    gen[0].expMis = 1'b0;
    e = mk(1'b0, 1'b0, 1'b0, 1'b1);
    e.chkRes    = 1'b1;
    e.expBursts = (doneB > 15) ? 15 : doneB;
    e.expCount  = enCnt % 16;
    e.expMis    = CHECK_ON && (v.injectCycle != 0);
    gen.push_back(e);
    e.done = 1'b0;
    gen.push_back(e);
    foreach (gen[i]) sbQ.push_back(gen[i]);

    @(posedge clk);
    #1;
    start     = 1'b1;
    stop      = 1'b0;
    run_len   = 8'(v.runLen);
    gap_len   = 8'(v.gapLen);
    burst_num = 4'(v.burstNum);
    for (int c = 1; (sbQ.size() > 0) && (c < 2000); c++) begin
      @(posedge clk);
      #1;
      start = (c == 2);
      stop  = (c == v.stopCycle);
      fault = (c == v.injectCycle);
      if (c == 1) begin
        run_len   = ~run_len;
        gap_len   = ~gap_len;
        burst_num = ~burst_num;
      end
      @(negedge clk);
      checkOutput(vi, c);
    end
    start = 1'b0;
    stop  = 1'b0;
    fault = 1'b0;
  endtask

  // A start that must be ignored: no activity for several cycles afterwards.
  task automatic pulseIgnored(input int runV, input bit stopV, input int vi);
    @(posedge clk);
    #1;
    start     = 1'b1;
    stop      = stopV;
    run_len   = 8'(runV);
    gap_len   = 8'd1;
    burst_num = 4'd1;
    for (int i = 0; i < 4; i++) sbQ.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      checkOutput(vi, c);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    run_len   = 8'd0;
    gap_len   = 8'd0;
    burst_num = 4'd0;
    fault     = 1'b0;

    vecs[0] = '{3, 2, 2,  0, 0};
    vecs[1] = '{4, 0, 3,  0, 0};
    vecs[2] = '{3, 1, 0, 11, 0};
    vecs[3] = '{1, 0, 1,  0, 0};
    vecs[4] = '{5, 3, 2,  0, 4};
    vecs[5] = '{2, 2, 1,  0, 0};
    vecs[6] = '{6, 0, 3,  0, 0};
    vecs[7] = '{1, 1, 15, 0, 0};
    vecs[8] = '{3, 0, 2,  1, 0};
    vecs[9] = '{2, 0, 0, 40, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("in reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkAllZero("after reset");

    pulseIgnored(0, 1'b0, 100);
    pulseIgnored(3, 1'b1, 101);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Reset asserted while in the gap between bursts.
    @(posedge clk);
    #1;
    start     = 1'b1;
    run_len   = 8'd3;
    gap_len   = 8'd4;
    burst_num = 4'd2;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 6) begin
        reset_n = 1'b0;
        #1;
        checkAllZero("async reset");
      end else begin
        @(negedge clk);
        if (c == 5) begin
          checkVal("pre-reset busy",        int'(busy),        1);
          checkVal("pre-reset enable",      int'(enable),      0);
          checkVal("pre-reset bursts_done", int'(bursts_done), 1);
        end
      end
    end
    @(negedge clk);
    checkAllZero("held reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkAllZero("released");
    applyStimulus('{3, 2, 2, 0, 0}, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
